// File: rtl/sram_bank_array.sv
// sram_bank_array: tiles sram16x16k macros into a DATA_W x (BANKS*16K) two-port
// array. It adds read-valid tracking, an optional output register, write/write
// arbitration (port A wins) and optional cross-port write-to-read forwarding.

// Behavioural model of the 16-bit x 16K-word two-port macro: 1-cycle read
// latency, read-before-write on a same-address cross-port access.
module sram16x16k (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iCEnA,
  input  logic        iWEnA,
  input  logic [15:0] iBWEnA,
  input  logic [13:0] iAddrA,
  input  logic [15:0] iWDataA,
  output logic [15:0] oRDataA,
  input  logic        iCEnB,
  input  logic        iWEnB,
  input  logic [15:0] iBWEnB,
  input  logic [13:0] iAddrB,
  input  logic [15:0] iWDataB,
  output logic [15:0] oRDataB
);
  logic [15:0] mem [16384];

  // Storage update: masked writes from both ports.
  // NOTE: the storage array is deliberately left out of reset; clearing 16K words is not possible in one cycle and contents must survive reset.
  always_ff @(posedge iClk) begin
    if (!iCEnA && !iWEnA) mem[iAddrA] <= (mem[iAddrA] & iBWEnA) | (iWDataA & ~iBWEnA);
    if (!iCEnB && !iWEnB) mem[iAddrB] <= (mem[iAddrB] & iBWEnB) | (iWDataB & ~iBWEnB);
  end

  // Read data registers: capture the pre-write word on a read.
  // NOTE: sequential state is written with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRDataA <= '0;
      oRDataB <= '0;
    end else begin
      if (!iCEnA && iWEnA) oRDataA <= mem[iAddrA];
      if (!iCEnB && iWEnB) oRDataB <= mem[iAddrB];
    end
  end
endmodule

module sram_bank_array #(
  parameter int DATA_W  = 32,
  parameter int BANKS   = 1,
  parameter int ADDR_W  = 14,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iCEnA,
  input  logic              iWEnA,
  input  logic [DATA_W-1:0] iBWEnA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iWDataA,
  output logic [DATA_W-1:0] oRDataA,
  output logic              oRValidA,
  input  logic              iCEnB,
  input  logic              iWEnB,
  input  logic [DATA_W-1:0] iBWEnB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iWDataB,
  output logic [DATA_W-1:0] oRDataB,
  output logic              oRValidB,
  output logic              oCollision
);
  localparam int LANES  = DATA_W / 16;
  localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  if (DATA_W < 16 || (DATA_W % 16) != 0) begin : g_chk_width
    $error("sram_bank_array: DATA_W must be a positive multiple of 16");
  end
  if (BANKS < 1 || (BANKS & (BANKS - 1)) != 0) begin : g_chk_banks
    $error("sram_bank_array: BANKS must be a power of 2");
  end
  if (ADDR_W != 14 + $clog2(BANKS)) begin : g_chk_addr
    $error("sram_bank_array: ADDR_W must equal 14 + log2(BANKS)");
  end

  logic [BSEL_W-1:0] bank_a, bank_b;
  if (BANKS > 1) begin : g_bsel
    assign bank_a = iAddrA[ADDR_W-1:14];
    assign bank_b = iAddrB[ADDR_W-1:14];
  end else begin : g_bsel_one
    assign bank_a = '0;
    assign bank_b = '0;
  end

  logic rd_a, wr_a, rd_b, wr_b, same_addr, ww_coll, byp_a, byp_b;
  assign rd_a      = ~iCEnA & iWEnA;
  assign wr_a      = ~iCEnA & ~iWEnA;
  assign rd_b      = ~iCEnB & iWEnB;
  assign wr_b      = ~iCEnB & ~iWEnB;
  assign same_addr = (iAddrA == iAddrB);
  assign ww_coll   = wr_a & wr_b & same_addr;
  assign byp_a     = (BYPASS != 0) & rd_a & wr_b & same_addr;
  assign byp_b     = (BYPASS != 0) & rd_b & wr_a & same_addr;

  logic [DATA_W-1:0] mac_rdata_a [BANKS];
  logic [DATA_W-1:0] mac_rdata_b [BANKS];

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic              cen_a, cen_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    // Only the addressed bank sees an active CEn; a losing port-B write is suppressed.
    assign cen_a = ~(~iCEnA & (bank_a == BSEL_W'(b)));
    assign cen_b = ~(~iCEnB & ~ww_coll & (bank_b == BSEL_W'(b)));
    assign mac_rdata_a[b] = rdata_a;
    assign mac_rdata_b[b] = rdata_b;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      sram16x16k u_macro (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iCEnA   (cen_a),
        .iWEnA   (iWEnA),
        .iBWEnA  (iBWEnA[16*l +: 16]),
        .iAddrA  (iAddrA[13:0]),
        .iWDataA (iWDataA[16*l +: 16]),
        .oRDataA (rdata_a[16*l +: 16]),
        .iCEnB   (cen_b),
        .iWEnB   (iWEnB),
        .iBWEnB  (iBWEnB[16*l +: 16]),
        .iAddrB  (iAddrB[13:0]),
        .iWDataB (iWDataB[16*l +: 16]),
        .oRDataB (rdata_b[16*l +: 16])
      );
    end
  end

  logic              rvld_a_q, rvld_b_q, byp_a_q, byp_b_q, coll_q;
  logic [BSEL_W-1:0] bsel_a_q, bsel_b_q;
  logic [DATA_W-1:0] byp_data_a_q, byp_mask_n_a_q, byp_data_b_q, byp_mask_n_b_q;

  // Read pipeline: valid, bank select and the forwarded write travel with the macro read.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rvld_a_q       <= 1'b0;
      rvld_b_q       <= 1'b0;
      bsel_a_q       <= '0;
      bsel_b_q       <= '0;
      byp_a_q        <= 1'b0;
      byp_b_q        <= 1'b0;
      byp_data_a_q   <= '0;
      byp_mask_n_a_q <= '0;
      byp_data_b_q   <= '0;
      byp_mask_n_b_q <= '0;
      coll_q         <= 1'b0;
    end else begin
      rvld_a_q <= rd_a;
      rvld_b_q <= rd_b;
      bsel_a_q <= bank_a;
      bsel_b_q <= bank_b;
      byp_a_q  <= byp_a;
      byp_b_q  <= byp_b;
      coll_q   <= ww_coll;
      if (byp_a) begin
        byp_data_a_q   <= iWDataB;
        byp_mask_n_a_q <= iBWEnB;
      end
      if (byp_b) begin
        byp_data_b_q   <= iWDataA;
        byp_mask_n_b_q <= iBWEnA;
      end
    end
  end

  logic [DATA_W-1:0] merged_a, merged_b;

  // Read-data mux plus overlay of forwarded bits (BWEn=0 bits take the new data).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
    merged_a = mac_rdata_a[bsel_a_q];
    merged_b = mac_rdata_b[bsel_b_q];
    if (byp_a_q) merged_a = (merged_a & byp_mask_n_a_q) | (byp_data_a_q & ~byp_mask_n_a_q);
    if (byp_b_q) merged_b = (merged_b & byp_mask_n_b_q) | (byp_data_b_q & ~byp_mask_n_b_q);
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              vld_a_q, vld_b_q;
    logic [DATA_W-1:0] dat_a_q, dat_b_q;
    // Output stage: data holds the last completed read until the next one.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        vld_a_q <= 1'b0;
        vld_b_q <= 1'b0;
        dat_a_q <= '0;
        dat_b_q <= '0;
      end else begin
        vld_a_q <= rvld_a_q;
        vld_b_q <= rvld_b_q;
        if (rvld_a_q) dat_a_q <= merged_a;
        if (rvld_b_q) dat_b_q <= merged_b;
      end
    end
    assign oRDataA  = dat_a_q;
    assign oRDataB  = dat_b_q;
    assign oRValidA = vld_a_q;
    assign oRValidB = vld_b_q;
  end else begin : g_out_comb
    assign oRDataA  = rvld_a_q ? merged_a : '0;
    assign oRDataB  = rvld_b_q ? merged_b : '0;
    assign oRValidA = rvld_a_q;
    assign oRValidB = rvld_b_q;
  end

  assign oCollision = coll_q;
endmodule
